// File: rtl/sym_timing_pkg.sv
// Shared types and constants for the symbol-timing controller.
// The lock detector is enabled by defining SYM_TIMING_LOCK_EN.
package sym_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ACQ   = 2'd2,
        ST_TRACK = 2'd3
    } state_t;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_FILL  = 2'd1;
    localparam logic [1:0] ENC_ACQ   = 2'd2;
    localparam logic [1:0] ENC_TRACK = 2'd3;

    // Nominal NCO increment: 2^wmu / osf, rounded to nearest.
    function automatic int unsigned nom_step(input int unsigned wmu, input int unsigned osf);
        longint unsigned full;
        longint unsigned q;
        full = 64'd1 << wmu;
        q = (full + 64'(osf / 2)) / 64'(osf);
        return 32'(q);
    endfunction

endpackage

// File: rtl/sym_timing_ctrl_lock_det.sv
// Lock detector: saturating sum of |error| over a fixed symbol window,
// compared against lock/unlock thresholds when the window completes.
module sym_lock_det
    import sym_timing_pkg::*;
#(
    parameter int unsigned WERR       = 18,
    parameter int unsigned LOCK_WIN   = 64,
    parameter int unsigned LOCK_THR   = 1 << 20,
    parameter int unsigned UNLOCK_THR = 1 << 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   active,
    input  logic signed [WERR-1:0] e_in,
    input  logic                   e_valid_in,
    output logic                   win_done,
    output logic                   win_low,
    output logic                   win_high
);

    localparam int unsigned WABS = WERR - 1;
    localparam int unsigned WSUM = WERR + $clog2(LOCK_WIN);
    localparam int unsigned WCNT = $clog2(LOCK_WIN + 1);
    localparam logic [WCNT-1:0] CNT_LAST = WCNT'(LOCK_WIN - 1);
    localparam logic signed [WERR-1:0] E_MIN = {1'b1, {WABS{1'b0}}};

    logic [WSUM-1:0]        sum_q;
    logic [WCNT-1:0]        cnt_q;
    logic signed [WERR-1:0] e_neg;
    logic [WABS-1:0]        e_abs;
    logic [WSUM:0]          sum_inc;
    logic [WSUM-1:0]        sum_sat;
    logic                   take;

    always_comb begin
        e_neg = -e_in;
        // The most negative error has no positive twin; pin it to max positive.
        if (e_in == E_MIN) begin
            e_abs = '1;
        end else if (e_in[WERR-1]) begin
            e_abs = e_neg[WABS-1:0];
        end else begin
            e_abs = e_in[WABS-1:0];
        end
        sum_inc = {1'b0, sum_q} + (WSUM + 1)'(e_abs);
        sum_sat = sum_inc[WSUM] ? '1 : sum_inc[WSUM-1:0];
    end

    assign take     = active && e_valid_in;
    assign win_done = take && (cnt_q == CNT_LAST);
    assign win_low  = 64'(sum_sat) < 64'(LOCK_THR);
    assign win_high = 64'(sum_sat) > 64'(UNLOCK_THR);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            if (cnt_q == CNT_LAST) begin
                sum_q <= '0;
                cnt_q <= '0;
            end else begin
                sum_q <= sum_sat;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sym_timing_ctrl.sv
// Symbol-timing controller: fill/acquire/track FSM around a mod-2^WMU NCO.
// Define SYM_TIMING_LOCK_EN to build in the lock detector and TRACK state.
module sym_timing_ctrl
    import sym_timing_pkg::*;
#(
    parameter int unsigned OSF        = 20,
    parameter int unsigned WMU        = 16,
    parameter int unsigned WERR       = 18,
    parameter int unsigned WCTL       = 12,
    parameter int unsigned CTRL_LIM   = 1024,
    parameter int unsigned LOCK_WIN   = 64,
    parameter int unsigned LOCK_THR   = 1 << 20,
    parameter int unsigned UNLOCK_THR = 1 << 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   iq_val,
    input  logic signed [WCTL-1:0] ctrl_i,
    input  logic signed [WERR-1:0] e_in,
    input  logic                   e_valid_in,
    output logic                   sym_valid_o,
    output logic [WMU-1:0]         mu_o,
    output logic                   gain_sel_o,
    output logic                   locked_o,
    output logic [1:0]             state_o
);

    localparam int NOM_STEP = int'(nom_step(WMU, OSF));
    localparam int CLIM     = int'(CTRL_LIM);
    localparam int ACC_MOD  = 1 << WMU;
    localparam int unsigned FILL_W = $clog2(OSF + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(OSF);

    state_t              state_q, state_d;
    logic [WMU-1:0]      acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                sym_q, sym_d;
    logic [WMU-1:0]      mu_q, mu_d;
    logic                gain_q, locked_q;

    logic signed [31:0]  ctrl_sat;
    logic signed [31:0]  nco_sum;
    logic                carry;
    logic [WMU-1:0]      acc_wrap;

    logic                win_done, win_low, win_high;

    // Signed sum of accumulator and clamped step; only an upward crossing
    // of 2^WMU counts as a symbol, a negative step just wraps.
    always_comb begin
        ctrl_sat = {{(32 - WCTL){ctrl_i[WCTL-1]}}, ctrl_i};
        if (ctrl_sat > CLIM) begin
            ctrl_sat = CLIM;
        end else if (ctrl_sat < -CLIM) begin
            ctrl_sat = -CLIM;
        end
        nco_sum  = $signed({{(32 - WMU){1'b0}}, acc_q}) + ctrl_sat + NOM_STEP;
        carry    = nco_sum >= ACC_MOD;
        acc_wrap = nco_sum[WMU-1:0];
    end

`ifdef SYM_TIMING_LOCK_EN
    logic lock_active;
    logic lock_clear;

    assign lock_active = (state_q == ST_ACQ) || (state_q == ST_TRACK);
    assign lock_clear  = !enable_i;

    sym_lock_det #(
        .WERR      (WERR),
        .LOCK_WIN  (LOCK_WIN),
        .LOCK_THR  (LOCK_THR),
        .UNLOCK_THR(UNLOCK_THR)
    ) u_lock_det (
        .clk       (clk),
        .reset     (reset),
        .clear     (lock_clear),
        .active    (lock_active),
        .e_in      (e_in),
        .e_valid_in(e_valid_in),
        .win_done  (win_done),
        .win_low   (win_low),
        .win_high  (win_high)
    );
`else
    localparam int unsigned UNUSED_LOCK_CFG = LOCK_WIN ^ LOCK_THR ^ UNLOCK_THR;
    logic unused_lock;

    assign unused_lock = ^{e_in, e_valid_in};
    assign win_done    = 1'b0;
    assign win_low     = 1'b0;
    assign win_high    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        sym_d   = 1'b0;
        mu_d    = mu_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            fill_d  = '0;
            mu_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
                ST_FILL: begin
                    if (iq_val) begin
                        if (fill_q == FILL_LAST) begin
                            state_d = ST_ACQ;
                            acc_d   = '0;
                            fill_d  = '0;
                        end else begin
                            fill_d = fill_q + 1'b1;
                        end
                    end
                end
                ST_ACQ, ST_TRACK: begin
                    if (iq_val) begin
                        acc_d = acc_wrap;
                        if (carry) begin
                            sym_d = 1'b1;
                            mu_d  = acc_wrap;
                        end
                    end
                    if (win_done) begin
                        if (state_q == ST_ACQ && win_low) begin
                            state_d = ST_TRACK;
                        end else if (state_q == ST_TRACK && win_high) begin
                            state_d = ST_ACQ;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            fill_q   <= '0;
            sym_q    <= 1'b0;
            mu_q     <= '0;
            gain_q   <= 1'b1;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fill_q   <= fill_d;
            sym_q    <= sym_d;
            mu_q     <= mu_d;
            gain_q   <= (state_d != ST_TRACK);
            locked_q <= (state_d == ST_TRACK);
        end
    end

    assign sym_valid_o = sym_q;
    assign mu_o        = mu_q;
    assign gain_sel_o  = gain_q;
    assign locked_o    = locked_q;
    assign state_o     = state_q;

endmodule
